// File: rtl/hazard_stall_ctrl.sv
// Pipeline sequencer for the 5-stage core: generates stage enables/flushes and
// the PC select from load-use, branch-redirect and data-memory-wait conditions.
module hazard_stall_ctrl #(
  parameter int ASIZE       = 4,
  parameter int MEM_TIMEOUT = 64,
  parameter int CNT_W       = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [ASIZE-1:0] id_rs_addr,
  input  logic [ASIZE-1:0] id_rt_addr,
  input  logic             id_rs_used,
  input  logic             id_rt_used,
  input  logic             idex_mem_read,
  input  logic             idex_wen,
  input  logic [ASIZE-1:0] idex_waddr,
  input  logic             exe_branch_taken,
  input  logic             mem_busy,
  output logic             pc_en,
  output logic             pc_sel,
  output logic             ifid_en,
  output logic             ifid_flush,
  output logic             idex_en,
  output logic             idex_flush,
  output logic             exmem_en,
  output logic             memwb_bubble,
  output logic             err,
  output logic [1:0]       state,
  output logic [CNT_W-1:0] stall_cycles
);

  localparam int WCW = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;
  localparam logic [WCW-1:0] WAIT_LAST = (MEM_TIMEOUT > 0) ? WCW'(MEM_TIMEOUT - 1) : '0;

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    MWAIT = 2'd1,
    ERR   = 2'd2
  } state_t;

  state_t           state_r;
  state_t           nxt_state_s;
  logic [WCW-1:0]   wait_cnt_r;
  logic [WCW-1:0]   nxt_wait_s;
  logic [CNT_W-1:0] stall_cnt_r;
  logic             lu_hazard_s;
  logic             timeout_hit_s;

  // Load in EXE whose destination is a live source of the ID instruction; r0 never hazards.
  always_comb begin
    lu_hazard_s = idex_mem_read & idex_wen & (idex_waddr != '0) &
                  ((id_rs_used & (id_rs_addr == idex_waddr)) |
                   (id_rt_used & (id_rt_addr == idex_waddr)));
  end

  // Last permitted busy cycle; a zero timeout never fires.
  always_comb begin
    timeout_hit_s = (MEM_TIMEOUT != 0) && (wait_cnt_r == WAIT_LAST);
  end

  // Next-state and Mealy outputs; memory wait outranks branch, branch outranks load-use.
  always_comb begin
    pc_en        = 1'b0;
    pc_sel       = 1'b0;
    ifid_en      = 1'b0;
    ifid_flush   = 1'b0;
    idex_en      = 1'b0;
    idex_flush   = 1'b0;
    exmem_en     = 1'b0;
    memwb_bubble = 1'b0;
    err          = 1'b0;
    nxt_state_s  = state_r;
    nxt_wait_s   = wait_cnt_r;
    if (rst) begin
      nxt_state_s = RUN;
      nxt_wait_s  = '0;
    end else begin
      case (state_r)
        ERR: begin
          memwb_bubble = 1'b1;
          err          = 1'b1;
        end
        RUN, MWAIT: begin
          if (mem_busy) begin
            memwb_bubble = 1'b1;
            nxt_state_s  = timeout_hit_s ? ERR : MWAIT;
            nxt_wait_s   = (wait_cnt_r == '1) ? wait_cnt_r : wait_cnt_r + WCW'(1);
          end else begin
            nxt_state_s = RUN;
            nxt_wait_s  = '0;
            if (exe_branch_taken) begin
              pc_en      = 1'b1;
              pc_sel     = 1'b1;
              ifid_en    = 1'b1;
              ifid_flush = 1'b1;
              idex_en    = 1'b1;
              idex_flush = 1'b1;
              exmem_en   = 1'b1;
            end else if (lu_hazard_s) begin
              idex_en    = 1'b1;
              idex_flush = 1'b1;
              exmem_en   = 1'b1;
            end else begin
              pc_en    = 1'b1;
              ifid_en  = 1'b1;
              idex_en  = 1'b1;
              exmem_en = 1'b1;
            end
          end
        end
        default: begin
          nxt_state_s = RUN;
          nxt_wait_s  = '0;
        end
      endcase
    end
  end

  // State, wait counter and saturating stall counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r     <= RUN;
      wait_cnt_r  <= '0;
      stall_cnt_r <= '0;
    end else begin
      state_r    <= nxt_state_s;
      wait_cnt_r <= nxt_wait_s;
      if (!pc_en && (state_r != ERR) && (stall_cnt_r != '1)) begin
        stall_cnt_r <= stall_cnt_r + CNT_W'(1);
      end else begin
        stall_cnt_r <= stall_cnt_r;
      end
    end
  end

  assign state        = state_r;
  assign stall_cycles = stall_cnt_r;

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// Directed bench for hazard_stall_ctrl: default instance, a MEM_TIMEOUT=4 instance
// and a MEM_TIMEOUT=0 / CNT_W=4 instance share one stimulus stream.
module tb_hazard_stall_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] id_rs_addr, id_rt_addr, idex_waddr;
  logic       id_rs_used, id_rt_used, idex_mem_read, idex_wen;
  logic       exe_branch_taken, mem_busy;

  logic        pc_en_m, pc_sel_m, ifid_en_m, ifid_flush_m, idex_en_m, idex_flush_m;
  logic        exmem_en_m, memwb_bubble_m, err_m;
  logic [1:0]  st_m;
  logic [15:0] sc_m;
  logic        pc_en_t, pc_sel_t, ifid_en_t, ifid_flush_t, idex_en_t, idex_flush_t;
  logic        exmem_en_t, memwb_bubble_t, err_t;
  logic [1:0]  st_t;
  logic [15:0] sc_t;
  logic        pc_en_s, pc_sel_s, ifid_en_s, ifid_flush_s, idex_en_s, idex_flush_s;
  logic        exmem_en_s, memwb_bubble_s, err_s;
  logic [1:0]  st_s;
  logic [3:0]  sc_s;

  logic [8:0] ctl_m, ctl_t, ctl_s;
  assign ctl_m = {pc_en_m, pc_sel_m, ifid_en_m, ifid_flush_m, idex_en_m, idex_flush_m, exmem_en_m, memwb_bubble_m, err_m};
  assign ctl_t = {pc_en_t, pc_sel_t, ifid_en_t, ifid_flush_t, idex_en_t, idex_flush_t, exmem_en_t, memwb_bubble_t, err_t};
  assign ctl_s = {pc_en_s, pc_sel_s, ifid_en_s, ifid_flush_s, idex_en_s, idex_flush_s, exmem_en_s, memwb_bubble_s, err_s};

  // {pc_en,pc_sel,ifid_en,ifid_flush,idex_en,idex_flush,exmem_en,memwb_bubble,err}
  localparam logic [8:0] C_RST  = 9'b0_0_0_0_0_0_0_0_0;
  localparam logic [8:0] C_NORM = 9'b1_0_1_0_1_0_1_0_0;
  localparam logic [8:0] C_LU   = 9'b0_0_0_0_1_1_1_0_0;
  localparam logic [8:0] C_BR   = 9'b1_1_1_1_1_1_1_0_0;
  localparam logic [8:0] C_BUSY = 9'b0_0_0_0_0_0_0_1_0;
  localparam logic [8:0] C_ERR  = 9'b0_0_0_0_0_0_0_1_1;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  hazard_stall_ctrl #(.ASIZE(4), .MEM_TIMEOUT(64), .CNT_W(16)) dut_m (
    .clk(clk), .rst(rst), .id_rs_addr(id_rs_addr), .id_rt_addr(id_rt_addr),
    .id_rs_used(id_rs_used), .id_rt_used(id_rt_used), .idex_mem_read(idex_mem_read),
    .idex_wen(idex_wen), .idex_waddr(idex_waddr), .exe_branch_taken(exe_branch_taken),
    .mem_busy(mem_busy), .pc_en(pc_en_m), .pc_sel(pc_sel_m), .ifid_en(ifid_en_m),
    .ifid_flush(ifid_flush_m), .idex_en(idex_en_m), .idex_flush(idex_flush_m),
    .exmem_en(exmem_en_m), .memwb_bubble(memwb_bubble_m), .err(err_m),
    .state(st_m), .stall_cycles(sc_m));

  hazard_stall_ctrl #(.ASIZE(4), .MEM_TIMEOUT(4), .CNT_W(16)) dut_t (
    .clk(clk), .rst(rst), .id_rs_addr(id_rs_addr), .id_rt_addr(id_rt_addr),
    .id_rs_used(id_rs_used), .id_rt_used(id_rt_used), .idex_mem_read(idex_mem_read),
    .idex_wen(idex_wen), .idex_waddr(idex_waddr), .exe_branch_taken(exe_branch_taken),
    .mem_busy(mem_busy), .pc_en(pc_en_t), .pc_sel(pc_sel_t), .ifid_en(ifid_en_t),
    .ifid_flush(ifid_flush_t), .idex_en(idex_en_t), .idex_flush(idex_flush_t),
    .exmem_en(exmem_en_t), .memwb_bubble(memwb_bubble_t), .err(err_t),
    .state(st_t), .stall_cycles(sc_t));

  hazard_stall_ctrl #(.ASIZE(4), .MEM_TIMEOUT(0), .CNT_W(4)) dut_s (
    .clk(clk), .rst(rst), .id_rs_addr(id_rs_addr), .id_rt_addr(id_rt_addr),
    .id_rs_used(id_rs_used), .id_rt_used(id_rt_used), .idex_mem_read(idex_mem_read),
    .idex_wen(idex_wen), .idex_waddr(idex_waddr), .exe_branch_taken(exe_branch_taken),
    .mem_busy(mem_busy), .pc_en(pc_en_s), .pc_sel(pc_sel_s), .ifid_en(ifid_en_s),
    .ifid_flush(ifid_flush_s), .idex_en(idex_en_s), .idex_flush(idex_flush_s),
    .exmem_en(exmem_en_s), .memwb_bubble(memwb_bubble_s), .err(err_s),
    .state(st_s), .stall_cycles(sc_s));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic clear_ops();
    id_rs_addr = 4'd0; id_rt_addr = 4'd0; id_rs_used = 1'b0; id_rt_used = 1'b0;
    idex_mem_read = 1'b0; idex_wen = 1'b0; idex_waddr = 4'd0;
    exe_branch_taken = 1'b0;
  endtask

  task automatic set_load_use_rs3();
    idex_mem_read = 1'b1; idex_wen = 1'b1; idex_waddr = 4'd3;
    id_rs_addr = 4'd3; id_rs_used = 1'b1;
  endtask

  initial begin
    clear_ops();
    mem_busy = 1'b0;
    rst = 1'b1;

    @(negedge clk); #1;
    chk("rst_ctl", 32'(ctl_m), 32'(C_RST));
    chk("rst_state", 32'(st_m), 32'd0);
    chk("rst_stall", 32'(sc_m), 32'd0);

    @(negedge clk); rst = 1'b0; #1;
    chk("run_ctl", 32'(ctl_m), 32'(C_NORM));
    chk("run_state", 32'(st_m), 32'd0);

    // load-use on rs: one bubble, then normal
    @(negedge clk); set_load_use_rs3(); #1;
    chk("lu_rs_ctl", 32'(ctl_m), 32'(C_LU));
    @(negedge clk); clear_ops(); #1;
    chk("lu_after_ctl", 32'(ctl_m), 32'(C_NORM));
    chk("lu_stall", 32'(sc_m), 32'd1);

    @(negedge clk); idex_mem_read = 1'b1; idex_wen = 1'b1; idex_waddr = 4'd0;
    id_rs_addr = 4'd0; id_rs_used = 1'b1; #1;
    chk("lu_r0_ctl", 32'(ctl_m), 32'(C_NORM));
    @(negedge clk); idex_waddr = 4'd3; id_rs_addr = 4'd3; id_rs_used = 1'b0; #1;
    chk("lu_unused_ctl", 32'(ctl_m), 32'(C_NORM));
    chk("lu_unused_stall", 32'(sc_m), 32'd1);
    @(negedge clk); id_rt_addr = 4'd3; id_rt_used = 1'b1; #1;
    chk("lu_rt_ctl", 32'(ctl_m), 32'(C_LU));

    // branch beats load-use
    @(negedge clk); exe_branch_taken = 1'b1; #1;
    chk("br_ctl", 32'(ctl_m), 32'(C_BR));
    chk("br_stall_before", 32'(sc_m), 32'd2);
    @(negedge clk); clear_ops(); #1;
    chk("br_after_ctl", 32'(ctl_m), 32'(C_NORM));
    chk("br_stall_after", 32'(sc_m), 32'd2);

    // 5-cycle memory wait; timeout instance trips after its 4th busy cycle
    for (int i = 0; i < 5; i++) begin
      @(negedge clk); mem_busy = 1'b1; #1;
      chk("mw_ctl", 32'(ctl_m), 32'(C_BUSY));
      chk("mw_state", 32'(st_m), (i == 0) ? 32'd0 : 32'd1);
    end
    @(negedge clk); mem_busy = 1'b0; #1;
    chk("mw_release_ctl", 32'(ctl_m), 32'(C_NORM));
    chk("mw_release_state", 32'(st_m), 32'd1);
    chk("mw_stall", 32'(sc_m), 32'd7);
    chk("to_state_early", 32'(st_t), 32'd2);
    @(negedge clk); #1;
    chk("mw_back_run", 32'(st_m), 32'd0);

    // branch held across a 3-cycle wait: redirect only in cycle 4
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); mem_busy = 1'b1; exe_branch_taken = 1'b1; #1;
      chk("sim_busy_ctl", 32'(ctl_m), 32'(C_BUSY));
    end
    @(negedge clk); mem_busy = 1'b0; #1;
    chk("sim_redirect_ctl", 32'(ctl_m), 32'(C_BR));
    @(negedge clk); exe_branch_taken = 1'b0; #1;
    chk("sim_after_ctl", 32'(ctl_m), 32'(C_NORM));
    chk("sim_stall", 32'(sc_m), 32'd10);

    // timeout with MEM_TIMEOUT=4
    @(negedge clk); rst = 1'b1; #1;
    chk("to_rst_ctl", 32'(ctl_t), 32'(C_RST));
    @(negedge clk); rst = 1'b0; mem_busy = 1'b1; #1;
    chk("to_busy_ctl", 32'(ctl_t), 32'(C_BUSY));
    for (int i = 1; i < 4; i++) begin
      @(negedge clk); #1;
      chk("to_wait_ctl", 32'(ctl_t), 32'(C_BUSY));
      chk("to_wait_state", 32'(st_t), 32'd1);
    end
    @(negedge clk); #1;
    chk("to_err_ctl", 32'(ctl_t), 32'(C_ERR));
    chk("to_err_state", 32'(st_t), 32'd2);
    chk("to_err_stall", 32'(sc_t), 32'd4);
    @(negedge clk); mem_busy = 1'b0; #1;
    chk("to_sticky_ctl", 32'(ctl_t), 32'(C_ERR));
    @(negedge clk); #1;
    chk("to_sticky_stall", 32'(sc_t), 32'd4);
    @(negedge clk); rst = 1'b1; #1;
    chk("to_rst2_ctl", 32'(ctl_t), 32'(C_RST));
    @(negedge clk); rst = 1'b0; #1;
    chk("to_clr_state", 32'(st_t), 32'd0);
    chk("to_clr_ctl", 32'(ctl_t), 32'(C_NORM));
    chk("to_clr_stall", 32'(sc_t), 32'd0);

    // 200 busy cycles: no timeout when disabled, 4-bit counter saturates, default trips at 64
    @(negedge clk); mem_busy = 1'b1;
    repeat (199) @(negedge clk);
    #1;
    chk("nto_state", 32'(st_s), 32'd1);
    chk("nto_ctl", 32'(ctl_s), 32'(C_BUSY));
    chk("nto_stall_sat", 32'(sc_s), 32'd15);
    chk("def_timeout_state", 32'(st_m), 32'd2);

    // reset in the middle of a wait
    @(negedge clk); rst = 1'b1; #1;
    chk("mid_rst_ctl", 32'(ctl_s), 32'(C_RST));
    @(negedge clk); rst = 1'b0; mem_busy = 1'b0; #1;
    chk("mid_rst_state", 32'(st_s), 32'd0);
    chk("mid_rst_stall", 32'(sc_s), 32'd0);
    chk("mid_rst_ctl_run", 32'(ctl_s), 32'(C_NORM));

    // 20 load-use stall cycles against the 4-bit counter
    @(negedge clk); set_load_use_rs3();
    repeat (3) @(negedge clk);
    #1;
    chk("sat_stall_3", 32'(sc_s), 32'd3);
    repeat (17) @(negedge clk);
    #1;
    chk("sat_stall_20", 32'(sc_s), 32'd15);
    chk("wide_stall_20", 32'(sc_m), 32'd20);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/hazard_stall_ctrl.md
Name: hazard_stall_ctrl

Overview:
- Central pipeline sequencer for the 5-stage 16-bit core.
- Decides each cycle whether PC, IF/ID, ID/EXE and EX/MEM advance, hold or are flushed.
- Handles load-use hazards, taken-branch redirects resolved in EXE, and multi-cycle data-memory waits, with a timeout error and a stall-cycle performance counter.
- Sits beside the stage registers and drives their enable/flush inputs and the PC mux select.

Parameters:
- ASIZE, 4, register-address width.
- MEM_TIMEOUT, 64, consecutive mem_busy cycles before error; 0 disables the timeout.
- CNT_W, 16, width of the stall-cycle counter.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous active-high reset.
- id_rs_addr  in  ASIZE  source reg 1 of the instruction in ID.
- id_rt_addr  in  ASIZE  source reg 2 of the instruction in ID.
- id_rs_used  in  1  ID instruction reads rs.
- id_rt_used  in  1  ID instruction reads rt.
- idex_mem_read  in  1  instruction in EXE is a load.
- idex_wen  in  1  instruction in EXE writes a register.
- idex_waddr  in  ASIZE  destination of the instruction in EXE.
- exe_branch_taken  in  1  branch in EXE resolved taken.
- mem_busy  in  1  data memory not ready this cycle.
- pc_en  out  1  PC loads this cycle.
- pc_sel  out  1  1 = PC loads the branch target, 0 = sequential.
- ifid_en  out  1  IF/ID loads.
- ifid_flush  out  1  IF/ID loads zeros (NOP).
- idex_en  out  1  ID/EXE loads.
- idex_flush  out  1  ID/EXE loads zeros (bubble).
- exmem_en  out  1  EX/MEM loads.
- memwb_bubble  out  1  MEM/WB loads a bubble.
- err  out  1  sticky memory-timeout error.
- state  out  2  FSM state: 0 RUN, 1 MWAIT, 2 ERR.
- stall_cycles  out  CNT_W  saturating count of cycles with pc_en=0, excluding reset and ERR.

Behaviour:
- Flush dominates enable: a flushed register loads zeros at the edge regardless of its enable.
- lu_hazard (combinational) = idex_mem_read & idex_wen & (idex_waddr != 0) & ((id_rs_used & id_rs_addr == idex_waddr) | (id_rt_used & id_rt_addr == idex_waddr)). Register 0 never hazards.
- Outputs are combinational (Mealy) on state plus inputs. State, wait_cnt and stall_cycles are registered.
- rst high: state <= RUN, wait_cnt <= 0, stall_cycles <= 0. In the same cycle all enables = 0, all flushes = 0, pc_sel = 0, memwb_bubble = 0, err = 0.
- ERR (2): all enables 0, flushes 0, pc_sel 0, memwb_bubble 1, err 1. Leaves only on rst.
- RUN or MWAIT, evaluated in priority order:
  1. mem_busy = 1: pc_en = ifid_en = idex_en = exmem_en = 0, memwb_bubble = 1. Branch and hazard are ignored. Next state is MWAIT and wait_cnt increments. If MEM_TIMEOUT != 0 and wait_cnt == MEM_TIMEOUT-1, next state is ERR.
  2. Otherwise, exe_branch_taken = 1: pc_en = 1, pc_sel = 1, ifid_flush = 1, idex_flush = 1, exmem_en = 1. The ID instruction is wrong-path, so lu_hazard is ignored.
  3. Otherwise, lu_hazard = 1: pc_en = 0, ifid_en = 0, idex_flush = 1, exmem_en = 1. This is exactly one bubble; the load reaches EX/MEM next cycle and the hazard clears.
  4. Otherwise: all enables 1, flushes 0, pc_sel 0.
  - In cases 2–4: next state is RUN and wait_cnt <= 0.
- Branch coinciding with mem_busy: ID/EXE is frozen, so exe_branch_taken stays asserted. The redirect happens in the first non-busy cycle, with no loss or duplication.
- mem_busy deasserting in MWAIT: the same cycle follows priorities 2–4 (zero-latency release).
- stall_cycles increments on every clock where pc_en = 0, state != ERR and rst = 0. It saturates at all-ones.
- wait_cnt is wide enough to hold MEM_TIMEOUT-1 and never wraps.

Test Plan:
- Load-use: EXE holds load to r3 (idex_mem_read=1, idex_wen=1, idex_waddr=3); ID has rs=3, rs_used=1 -> one cycle of pc_en=0, ifid_en=0, idex_flush=1; next cycle normal; stall_cycles=1. Repeat with idex_waddr=0, or rs=3 with rs_used=0 -> no stall.
- Branch: exe_branch_taken=1 for one cycle while lu_hazard is also true -> pc_sel=1, pc_en=1, ifid_flush=1, idex_flush=1; no stall; stall_cycles unchanged.
- Memory wait: mem_busy=1 for 5 cycles -> state=1 during the wait, all enables 0, memwb_bubble=1 for 5 cycles; release cycle returns to normal; stall_cycles=5, wait_cnt back to 0.
- Simultaneous: mem_busy=1 for 3 cycles with exe_branch_taken held high -> no redirect during the wait; pc_sel=1 pulses exactly once, in cycle 4.
- Timeout: MEM_TIMEOUT=4, mem_busy held high -> state=ERR and err=1 after the 4th busy cycle; busy dropping leaves err=1; rst returns state=0, err=0, stall_cycles=0. With MEM_TIMEOUT=0, 200 busy cycles -> no error.
- Saturation: CNT_W=4, 20 stall cycles -> stall_cycles=15. Asserting rst mid-MWAIT -> RUN next cycle, all counters 0.
